// File: rtl/hazard_scoreboard.sv
// Data-hazard scoreboard: tracks in-flight register writes over DEPTH stages and
// produces per-operand forwarding selects, the active-low stall DHS and a stall counter.
module hazard_scoreboard #(
  parameter int AW    = 3,
  parameter int DEPTH = 2,
  parameter int MODE  = 1,
  parameter int CNT_W = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         dv,
  input  logic [AW-1:0]                AA,
  input  logic [AW-1:0]                BA,
  input  logic                         MA,
  input  logic                         MB,
  input  logic [AW-1:0]                DA,
  input  logic                         RW,
  input  logic                         LD,
  input  logic                         flush,
  output logic                         DHS,
  output logic [$clog2(DEPTH+1)-1:0]   fwd_a,
  output logic [$clog2(DEPTH+1)-1:0]   fwd_b,
  output logic [CNT_W-1:0]             stall_cnt
);

  localparam int SW = $clog2(DEPTH+1);
  // A load result only becomes forwardable once it has left entry 0.
  localparam logic [DEPTH-1:0] LATE_MASK = DEPTH'(1);

  logic [DEPTH-1:0] v_reg;
  logic [DEPTH-1:0] ld_reg;
  logic [AW-1:0]    a_reg [DEPTH];
  logic [CNT_W-1:0] cnt_reg;

  logic [DEPTH-1:0] match_a, match_b;
  logic [DEPTH-1:0] win_a, win_b;
  logic [SW-1:0]    sel_a, sel_b;
  logic             active, any_match, load_use, stall;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_match
      assign match_a[gi] = dv & ~MA & v_reg[gi] & (a_reg[gi] == AA) & (AA != '0);
      assign match_b[gi] = dv & ~MB & v_reg[gi] & (a_reg[gi] == BA) & (BA != '0);
    end
  endgenerate

  // Isolate the youngest (lowest-index) match as a one-hot vector.
  assign win_a = match_a & (~match_a + DEPTH'(1));
  assign win_b = match_b & (~match_b + DEPTH'(1));

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (match_a[i]) sel_a = SW'(i + 1);
      if (match_b[i]) sel_b = SW'(i + 1);
    end
  end

  assign active    = dv & ~flush;
  assign any_match = (|match_a) | (|match_b);
  assign load_use  = |((win_a | win_b) & ld_reg & LATE_MASK);
  assign stall     = active & ((MODE == 0) ? any_match : load_use);

  always_comb begin
    DHS   = ~stall;
    fwd_a = '0;
    fwd_b = '0;
    if (MODE != 0 && active && !stall) begin
      fwd_a = sel_a;
      fwd_b = sel_b;
    end
  end

  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      if (gi == 0) begin : g_head
        // Stalled or flushed decode enters a bubble.
        always_ff @(posedge clk) begin
          if (rst) begin
            v_reg[0]  <= 1'b0;
            ld_reg[0] <= 1'b0;
            a_reg[0]  <= '0;
          end else begin
            v_reg[0]  <= dv & RW & (DA != '0) & ~stall & ~flush;
            ld_reg[0] <= LD;
            a_reg[0]  <= DA;
          end
        end
      end else begin : g_shift
        always_ff @(posedge clk) begin
          if (rst) begin
            v_reg[gi]  <= 1'b0;
            ld_reg[gi] <= 1'b0;
            a_reg[gi]  <= '0;
          end else begin
            v_reg[gi]  <= v_reg[gi-1];
            ld_reg[gi] <= ld_reg[gi-1];
            a_reg[gi]  <= a_reg[gi-1];
          end
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (stall && !(&cnt_reg)) begin
      cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

  assign stall_cnt = cnt_reg;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench: one stall-only instance (narrow counter) and one forwarding instance
// share the decode inputs; each step checks the instance the step targets.
module tb_hazard_scoreboard;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, dv, ma, mb, rw, ld, flush;
  logic [2:0] aa, ba, da;

  logic        dhs0, dhs1;
  logic [1:0]  fa0, fb0, fa1, fb1;
  logic [3:0]  cnt0;
  logic [15:0] cnt1;

  int n_assert = 0;
  int n_fail   = 0;

  hazard_scoreboard #(.AW(3), .DEPTH(2), .MODE(0), .CNT_W(4)) u_m0 (
    .clk(clk), .rst(rst), .dv(dv), .AA(aa), .BA(ba), .MA(ma), .MB(mb),
    .DA(da), .RW(rw), .LD(ld), .flush(flush),
    .DHS(dhs0), .fwd_a(fa0), .fwd_b(fb0), .stall_cnt(cnt0)
  );

  hazard_scoreboard #(.AW(3), .DEPTH(2), .MODE(1), .CNT_W(16)) u_m1 (
    .clk(clk), .rst(rst), .dv(dv), .AA(aa), .BA(ba), .MA(ma), .MB(mb),
    .DA(da), .RW(rw), .LD(ld), .flush(flush),
    .DHS(dhs1), .fwd_a(fa1), .fwd_b(fb1), .stall_cnt(cnt1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Apply one decode slot, then let combinational outputs settle.
  task automatic slot(input logic v, input logic [2:0] a, input logic m_a,
                      input logic [2:0] b, input logic m_b, input logic [2:0] d,
                      input logic w, input logic l, input logic f);
    dv = v; aa = a; ma = m_a; ba = b; mb = m_b; da = d; rw = w; ld = l; flush = f;
    #1;
    $display("slot t=%0t dv=%0b AA=%0d MA=%0b BA=%0d MB=%0b DA=%0d RW=%0b LD=%0b fl=%0b | m0 DHS=%0b cnt=%0d | m1 DHS=%0b fa=%0d fb=%0d cnt=%0d",
             $time, v, a, m_a, b, m_b, d, w, l, f, dhs0, cnt0, dhs1, fa1, fb1, cnt1);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    slot(0, 0, 1, 0, 1, 0, 0, 0, 0);
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    dv = 0; aa = 0; ba = 0; ma = 1; mb = 1; da = 0; rw = 0; ld = 0; flush = 0;

    // 1 reset
    do_reset();
    slot(0, 0, 1, 0, 1, 0, 0, 0, 0);
    chk("rst_dhs0", dhs0, 1);
    chk("rst_dhs1", dhs1, 1);
    chk("rst_fa1", fa1, 0);
    chk("rst_fb1", fb1, 0);
    chk("rst_cnt0", cnt0, 0);
    chk("rst_cnt1", cnt1, 0);

    // 2 MODE=0: writer R3 then consumer of R3 stalls two cycles
    slot(1, 0, 1, 0, 1, 3, 1, 0, 0);
    chk("m0_writer_dhs", dhs0, 1);
    tick();
    slot(1, 3, 0, 0, 1, 0, 0, 0, 0);
    chk("m0_stall1_dhs", dhs0, 0);
    chk("m0_stall1_fa", fa0, 0);
    chk("m1_fwd_same", fa1, 1);
    tick();
    slot(1, 3, 0, 0, 1, 0, 0, 0, 0);
    chk("m0_stall2_dhs", dhs0, 0);
    tick();
    slot(1, 3, 0, 0, 1, 0, 0, 0, 0);
    chk("m0_release_dhs", dhs0, 1);
    chk("m0_cnt2", cnt0, 2);
    tick();

    // 3 register 0 and immediate operand
    slot(1, 0, 1, 0, 1, 0, 1, 0, 0);
    tick();
    slot(1, 0, 0, 0, 1, 0, 0, 0, 0);
    chk("r0_dhs0", dhs0, 1);
    tick();
    slot(1, 0, 1, 0, 1, 4, 1, 0, 0);
    tick();
    slot(1, 0, 1, 4, 1, 0, 0, 0, 0);
    chk("imm_dhs0", dhs0, 1);
    chk("imm_fb0", fb0, 0);
    chk("imm_fb1", fb1, 0);
    tick();

    // 4 MODE=1 forwarding
    do_reset();
    slot(1, 0, 1, 0, 1, 5, 1, 0, 0);
    tick();
    slot(1, 5, 0, 0, 1, 0, 0, 0, 0);
    chk("fwd1_dhs1", dhs1, 1);
    chk("fwd1_fa1", fa1, 1);
    tick();
    tick();
    slot(1, 0, 1, 0, 1, 5, 1, 0, 0);
    tick();
    slot(0, 0, 1, 0, 1, 0, 0, 0, 0);
    tick();
    slot(1, 5, 0, 0, 1, 0, 0, 0, 0);
    chk("fwd2_fa1", fa1, 2);
    chk("fwd2_dhs1", dhs1, 1);
    tick();
    tick();
    slot(1, 0, 1, 0, 1, 5, 1, 0, 0);
    tick();
    slot(1, 0, 1, 0, 1, 5, 1, 0, 0);
    tick();
    slot(1, 5, 0, 0, 1, 0, 0, 0, 0);
    chk("youngest_fa1", fa1, 1);
    tick();
    tick();
    // A and B hit different entries
    slot(1, 0, 1, 0, 1, 6, 1, 0, 0);
    tick();
    slot(1, 0, 1, 0, 1, 7, 1, 0, 0);
    tick();
    slot(1, 6, 0, 7, 0, 0, 0, 0, 0);
    chk("split_fa1", fa1, 2);
    chk("split_fb1", fb1, 1);
    chk("m1_no_stall_cnt", cnt1, 0);
    tick();

    // 5 load-use
    do_reset();
    slot(1, 0, 1, 0, 1, 2, 1, 1, 0);
    tick();
    slot(1, 2, 0, 2, 0, 0, 0, 0, 0);
    chk("lu_stall_dhs1", dhs1, 0);
    chk("lu_stall_fb1", fb1, 0);
    tick();
    slot(1, 2, 0, 2, 0, 0, 0, 0, 0);
    chk("lu_go_dhs1", dhs1, 1);
    chk("lu_go_fb1", fb1, 2);
    chk("lu_go_fa1", fa1, 2);
    chk("lu_cnt1", cnt1, 1);
    tick();

    // 6 flush, mid-operation reset, saturation
    do_reset();
    slot(1, 0, 1, 0, 1, 3, 1, 0, 0);
    tick();
    slot(1, 3, 0, 0, 1, 4, 1, 0, 1);
    chk("flush_dhs0", dhs0, 1);
    chk("flush_dhs1", dhs1, 1);
    chk("flush_fa1", fa1, 0);
    tick();
    slot(1, 0, 1, 4, 0, 0, 0, 0, 0);
    chk("flush_noentry_dhs0", dhs0, 1);
    chk("flush_noentry_fb1", fb1, 0);
    chk("flush_cnt0", cnt0, 0);
    tick();

    slot(1, 0, 1, 0, 1, 3, 1, 0, 0);
    tick();
    rst = 1'b1;
    slot(0, 0, 1, 0, 1, 0, 0, 0, 0);
    tick();
    rst = 1'b0;
    slot(1, 3, 0, 0, 1, 0, 0, 0, 0);
    chk("midrst_dhs0", dhs0, 1);
    chk("midrst_fa1", fa1, 0);
    tick();

    do_reset();
    for (int r = 0; r < 10; r++) begin
      slot(1, 0, 1, 0, 1, 3, 1, 0, 0);
      tick();
      slot(1, 3, 0, 0, 1, 0, 0, 0, 0);
      tick();
      tick();
    end
    slot(0, 0, 1, 0, 1, 0, 0, 0, 0);
    chk("sat_cnt0", cnt0, 15);
    chk("sat_dhs0", dhs0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
